regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
  - Requester A: ALU writeback, primary.
  - Requester B: load / multi-cycle unit, secondary.
- Uses valid/ready handshakes and fixed priority, with a starvation boost for B.
- Stages the granted write in an output register that drives the register file's regWrite/writeReg/writeData.
- Forwards the staged write onto the two read paths, so reads issued while a write is in flight return the new value.

Parameters:
- DATA_W, 32, data width of write and read data.
- ADDR_W, 5, register index width.
- STARVE_LIMIT, 4, consecutive cycles B may be refused before it takes priority (range 1..15).
- ZERO_PROTECT, 1, when 1, writes to register 0 are accepted but never issued.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  A write request.
- a_ready  output  1  A request accepted this cycle (combinational).
- a_reg  input  ADDR_W  A destination register.
- a_data  input  DATA_W  A write data.
- b_valid  input  1  B write request.
- b_ready  output  1  B request accepted this cycle (combinational).
- b_reg  input  ADDR_W  B destination register.
- b_data  input  DATA_W  B write data.
- regWrite  output  1  register-file write enable (registered).
- writeReg  output  ADDR_W  register-file write index (registered).
- writeData  output  DATA_W  register-file write data (registered).
- readReg1  input  ADDR_W  read index, port 1.
- readReg2  input  ADDR_W  read index, port 2.
- rf_data1  input  DATA_W  raw register-file read data, port 1.
- rf_data2  input  DATA_W  raw register-file read data, port 2.
- fwd_data1  output  DATA_W  forwarded read data, port 1 (combinational).
- fwd_data2  output  DATA_W  forwarded read data, port 2 (combinational).
- b_boost  output  1  B currently holds priority (registered).

Behaviour:
- Reset (async, immediate): regWrite=0, writeReg=0, writeData=0, b_boost=0, starvation counter=0. A staged write present at reset is discarded and never reaches the register file.
- Transfer rule: a transfer occurs when valid && ready. Requesters hold valid/reg/data stable until ready; a request may be withdrawn only after acceptance.
- Sink rule: a request is "sunk" when ZERO_PROTECT=1 and its reg==0.
  - A sunk request sees ready=1 in the same cycle, regardless of arbitration.
  - It issues no write and does not use the write slot.
- Arbitration over non-sunk requests, at most one grant per cycle:
  - b_boost=0: A wins; B is granted only if A is not requesting.
  - b_boost=1: B wins; A is granted only if B is not requesting.
- Starvation counter, evaluated each edge:
  - Cleared on any B acceptance (granted or sunk).
  - Otherwise, incremented while B is valid, non-sunk and refused; saturates at STARVE_LIMIT.
  - b_boost is set the cycle after the counter reaches STARVE_LIMIT, and cleared the cycle after B is accepted.
- Write staging, on the rising edge after a grant:
  - regWrite=1, writeReg and writeData take the granted request's values.
  - With no grant, regWrite=0 and writeReg/writeData hold their previous values.
  - Latency from handshake to the register file's write edge: 1 cycle for staging, landing on the following edge. Back-to-back grants produce back-to-back writes at full throughput.
- Same-register collision: when A and B target the same register in one cycle, only the winner writes. The loser writes later, so the last write to complete is the surviving value.
- Forwarding, per port n:
  - fwd_datan = writeData when regWrite=1 and writeReg==readRegn (and readRegn!=0 if ZERO_PROTECT=1).
  - Otherwise fwd_datan = rf_datan.
  - Forwarding reflects only the staged write, not same-cycle requests.
- With ZERO_PROTECT=0, register 0 is an ordinary register: it is arbitrated, written and forwarded.

Decomposition:
- Shared package (regfile_pkg): DATA_W/ADDR_W defaults, ZERO_REG index constant, and the grant encoding (GNT_NONE, GNT_A, GNT_B).
- One sub-module, wb_prio_arb: combinational grant logic plus the starvation counter and b_boost register.
- Staging register and forwarding muxes live in the top level.

Test Plan:
- Reset mid-operation: grant A (reg 5, data 0x11), then assert rst before the next edge -> regWrite=0, writeReg=0, writeData=0, b_boost=0 immediately; no write to reg 5.
- Single request: A only (reg 16, data 6) -> a_ready=1 that cycle; next edge regWrite=1, writeReg=16, writeData=6; following cycle regWrite=0 if idle.
- Contention: A and B continuously valid (A reg 3 data 0xA, B reg 4 data 0xB), STARVE_LIMIT=4 -> A granted 4 cycles, b_boost=1 the cycle after the count reaches 4, B granted exactly once, then b_boost=0 and A resumes.
- Zero sink: A reg 0 data 4, B reg 7 data 9, both valid, ZERO_PROTECT=1 -> a_ready=1 and b_ready=1 same cycle; next edge writeReg=7, writeData=9; reg 0 never written.
- Forwarding: stage write reg 16 data 6 while readReg1=16, rf_data1=0 -> fwd_data1=6. With readReg2=0 and rf_data2=0 -> fwd_data2=0.
- Same-register collision: A and B both reg 9 (A 0x1, B 0x2), b_boost=0 -> writes issue A then B on consecutive edges; final reg 9 = 0x2.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, the register-0 index and the grant encoding used by the
// writeback arbiter and its priority sub-block.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } gnt_e;

endpackage

// File: rtl/wb_prio_arb.sv
// Fixed-priority grant between the two writeback requesters, with a
// starvation counter that hands priority to B after repeated refusals.
module wb_prio_arb
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic b_sunk_i,
  output gnt_e gnt_o,
  output logic boost_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q, cnt_d;
  logic       boost_q, boost_d;
  logic       b_acc;
  gnt_e       gnt;

  always_comb begin
    gnt = GNT_NONE;
    if (boost_q) begin
      if (b_req_i)      gnt = GNT_B;
      else if (a_req_i) gnt = GNT_A;
    end else begin
      if (a_req_i)      gnt = GNT_A;
      else if (b_req_i) gnt = GNT_B;
    end
  end

  // Any B acceptance, including a sunk register-0 write, ends the starvation run.
  assign b_acc = b_sunk_i || (gnt == GNT_B);

  always_comb begin
    cnt_d = cnt_q;
    if (b_acc)
      cnt_d = 4'd0;
    else if (b_req_i && (cnt_q != LIMIT))
      cnt_d = cnt_q + 4'd1;
    boost_d = !b_acc && (cnt_d == LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      boost_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      boost_q <= boost_d;
    end
  end

  assign gnt_o   = gnt;
  assign boost_o = boost_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between ALU (A) and load (B)
// writebacks, stages the granted write and forwards it onto both read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int ZERO_PROTECT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              b_boost
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic              ZP_EN    = (ZERO_PROTECT != 0);

  logic a_sunk, b_sunk, a_req, b_req, boost;
  gnt_e gnt;

  logic              regWrite_q, regWrite_d;
  logic [ADDR_W-1:0] writeReg_q, writeReg_d;
  logic [DATA_W-1:0] writeData_q, writeData_d;

  // Register-0 writes are swallowed at the handshake and never reach arbitration.
  assign a_sunk = ZP_EN && (a_reg == ZERO_IDX);
  assign b_sunk = ZP_EN && (b_reg == ZERO_IDX);
  assign a_req  = a_valid && !a_sunk;
  assign b_req  = b_valid && !b_sunk;

  wb_prio_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .a_req_i (a_req),
    .b_req_i (b_req),
    .b_sunk_i(b_valid && b_sunk),
    .gnt_o   (gnt),
    .boost_o (boost)
  );

  assign a_ready = (a_valid && a_sunk) || (gnt == GNT_A);
  assign b_ready = (b_valid && b_sunk) || (gnt == GNT_B);

  always_comb begin
    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    unique case (gnt)
      GNT_A: begin
        regWrite_d  = 1'b1;
        writeReg_d  = a_reg;
        writeData_d = a_data;
      end
      GNT_B: begin
        regWrite_d  = 1'b1;
        writeReg_d  = b_reg;
        writeData_d = b_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
    end
  end

  assign regWrite  = regWrite_q;
  assign writeReg  = writeReg_q;
  assign writeData = writeData_q;
  assign b_boost   = boost;

  logic [ADDR_W-1:0] rd_idx [2];
  logic [DATA_W-1:0] rd_raw [2];
  logic [DATA_W-1:0] rd_fwd [2];

  assign rd_idx[0] = readReg1;
  assign rd_idx[1] = readReg2;
  assign rd_raw[0] = rf_data1;
  assign rd_raw[1] = rf_data2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic hit;
    assign hit = regWrite_q && (writeReg_q == rd_idx[gi]) &&
                 !(ZP_EN && (rd_idx[gi] == ZERO_IDX));
    assign rd_fwd[gi] = hit ? writeData_q : rd_raw[gi];
  end

  assign fwd_data1 = rd_fwd[0];
  assign fwd_data2 = rd_fwd[1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts handshakes, boost
// and forwarding; predicted writes are queued and checked by a separate monitor.
module tb_regfile_wb_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_reg, b_reg, writeReg, readReg1, readReg2;
  logic [DW-1:0] a_data, b_data, writeData, rf_data1, rf_data2, fwd_data1, fwd_data2;
  logic          regWrite, b_boost;

  logic [DW-1:0] rf [32] = '{default: '0};

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM), .ZERO_PROTECT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .b_boost(b_boost)
  );

  always #5 clk = ~clk;

  // Behavioural register file driven by the DUT's write port.
  always @(posedge clk) if (!rst && regWrite) rf[writeReg] <= writeData;
  assign rf_data1 = rf[readReg1];
  assign rf_data2 = rf[readReg2];

  typedef struct {
    bit            v;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wb_t;

  wb_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  // Reference state: refusals of B in a row, priority flag, last staged write.
  int            m_refusals;
  bit            m_boost;
  bit            stg_v;
  logic [AW-1:0] stg_r;
  logic [DW-1:0] stg_d;
  bit            a_acc, b_acc;
  bit            dut_b_ready;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      wb_t e;
      e = exp_q.pop_front();
      chk("regWrite", {31'b0, regWrite}, {31'b0, e.v});
      chk("writeReg", {27'b0, writeReg}, {27'b0, e.r});
      chk("writeData", writeData, e.d);
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_refusals = 0;
    m_boost    = 1'b0;
    stg_v      = 1'b0;
    stg_r      = '0;
    stg_d      = '0;
  endtask

  // One cycle: inputs already driven at the negedge; predict and compare.
  task automatic step();
    bit            sa, sb, ra, rb, ga, gb, ea, eb;
    logic [DW-1:0] e1, e2;
    #1;
    sa = a_valid && (a_reg == 0);
    sb = b_valid && (b_reg == 0);
    ra = a_valid && !sa;
    rb = b_valid && !sb;
    if (m_boost) begin
      gb = rb;
      ga = ra && !rb;
    end else begin
      ga = ra;
      gb = rb && !ra;
    end
    ea = sa || ga;
    eb = sb || gb;
    chk("a_ready", {31'b0, a_ready}, {31'b0, ea});
    chk("b_ready", {31'b0, b_ready}, {31'b0, eb});
    chk("b_boost", {31'b0, b_boost}, {31'b0, m_boost});
    e1 = (stg_v && stg_r == readReg1 && readReg1 != 0) ? stg_d : rf_data1;
    e2 = (stg_v && stg_r == readReg2 && readReg2 != 0) ? stg_d : rf_data2;
    chk("fwd_data1", fwd_data1, e1);
    chk("fwd_data2", fwd_data2, e2);
    dut_b_ready = b_ready;
    if (eb) m_refusals = 0;
    else if (rb && m_refusals < LIM) m_refusals++;
    m_boost = !eb && (m_refusals == LIM);
    stg_v = ga || gb;
    if (ga) begin stg_r = a_reg; stg_d = a_data; end
    else if (gb) begin stg_r = b_reg; stg_d = b_data; end
    exp_q.push_back('{stg_v, stg_r, stg_d});
    a_acc = ea;
    b_acc = eb;
    @(negedge clk);
  endtask

  initial begin
    logic [8:0] b_pat;
    rst = 1'b1;
    a_valid = 0; b_valid = 0; a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    readReg1 = '0; readReg2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_regWrite", {31'b0, regWrite}, 32'd0);
    chk("rst_writeReg", {27'b0, writeReg}, 32'd0);
    chk("rst_b_boost", {31'b0, b_boost}, 32'd0);
    rst = 1'b0;

    // Single A write with forwarding on port 1, register 0 on port 2.
    a_valid = 1; a_reg = 16; a_data = 6; readReg1 = 16; readReg2 = 0;
    step();
    a_valid = 0;
    #1;
    chk("fwd1_staged", fwd_data1, 32'd6);
    chk("fwd2_zero", fwd_data2, 32'd0);
    step();
    step();

    // Register-0 request is sunk while B takes the slot.
    a_valid = 1; a_reg = 0; a_data = 4; b_valid = 1; b_reg = 7; b_data = 9;
    step();
    a_valid = 0; b_valid = 0;
    step(); step();
    chk("rf7", rf[7], 32'd9);

    // Same-register collision: A then B, B's value survives.
    a_valid = 1; a_reg = 9; a_data = 1; b_valid = 1; b_reg = 9; b_data = 2;
    step();
    if (a_acc) a_valid = 0;
    step();
    if (b_acc) b_valid = 0;
    step(); step();
    chk("rf9_final", rf[9], 32'd2);

    // Continuous contention: B wins only on the boosted cycle.
    a_valid = 1; a_reg = 3; a_data = 32'hA; b_valid = 1; b_reg = 4; b_data = 32'hB;
    for (int i = 0; i < 9; i++) begin
      step();
      b_pat[i] = dut_b_ready;
    end
    chk("contention_pattern", {23'b0, b_pat}, 32'h010);
    b_valid = 0;

    // Reset while a granted write is staged: it must never land.
    a_reg = 5; a_data = 32'h11;
    step();
    a_valid = 0;
    #1;
    chk("boost_before_rst", {31'b0, b_boost}, 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_regWrite", {31'b0, regWrite}, 32'd0);
    chk("mid_rst_writeReg", {27'b0, writeReg}, 32'd0);
    chk("mid_rst_writeData", writeData, 32'd0);
    chk("mid_rst_b_boost", {31'b0, b_boost}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rf5_untouched", rf[5], 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1; a_reg = AW'($urandom_range(0, 7)); a_data = $urandom;
      end
      if (!b_valid && $urandom_range(0, 2) != 0) begin
        b_valid = 1; b_reg = AW'($urandom_range(0, 7)); b_data = $urandom;
      end
      readReg1 = ($urandom_range(0, 1) == 1) ? stg_r : AW'($urandom_range(0, 7));
      readReg2 = AW'($urandom_range(0, 7));
      step();
      if (a_acc) a_valid = 0;
      if (b_acc) b_valid = 0;
    end
    a_valid = 0; b_valid = 0;
    step(); step(); step();
    chk("rf0_never_written", rf[0], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
